// File: rtl/mem_phase_seq.sv
// mem_phase_seq: sequences two insn fetches and one data access over one BRAM port.
// Ports: clk, rst; req_* request handshake in; rsp_* response out; m_* BRAM side; err.
// Option: define MEM_BOUNDS_CHECK_EN to flag out-of-range addresses and block those stores.
module mem_phase_seq #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_i1a,
  input  logic [ADDR_W-1:0] req_i2a,
  input  logic [ADDR_W-1:0] req_da,
  input  logic [DATA_W-1:0] req_din,
  input  logic              req_we,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_i1,
  output logic [DATA_W-1:0] rsp_i2,
  output logic [DATA_W-1:0] rsp_d,
  output logic              m_i1re,
  output logic              m_i2re,
  output logic              m_dre,
  output logic              m_gwe,
  output logic [ADDR_W-1:0] m_i1addr,
  output logic [ADDR_W-1:0] m_i2addr,
  output logic [ADDR_W-1:0] m_daddr,
  output logic [DATA_W-1:0] m_din,
  output logic              m_dwe,
  input  logic [DATA_W-1:0] m_i1out,
  input  logic [DATA_W-1:0] m_i2out,
  input  logic [DATA_W-1:0] m_dout,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3
  } state_t;

  state_t state;
  state_t state_nx;
  logic   accept;
  logic   we_ok;
  logic   we_q;

  // P3 overlaps with the next accept so
  // back-to-back requests see no gap.
  assign req_ready = (state == IDLE || state == P3) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? P0 : IDLE;
      P0:      state_nx = P1;
      P1:      state_nx = P2;
      P2:      state_nx = P3;
      P3:      state_nx = accept ? P0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob;

  assign oob = (32'(req_i1a) >= MEM_DEPTH)
            || (32'(req_i2a) >= MEM_DEPTH)
            || (32'(req_da) >= MEM_DEPTH);
  assign we_ok = 32'(req_da) < MEM_DEPTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && oob) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_depth;

  assign unused_depth = ^32'(MEM_DEPTH);
  assign we_ok        = 1'b1;
  assign err          = 1'b0;
`endif

  // Strobes and store enable are decoded from
  // the next state so they are registered and
  // line up exactly with the phase they name.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      m_i1re    <= 1'b0;
      m_i2re    <= 1'b0;
      m_dre     <= 1'b0;
      m_gwe     <= 1'b0;
      m_dwe     <= 1'b0;
      m_i1addr  <= '0;
      m_i2addr  <= '0;
      m_daddr   <= '0;
      m_din     <= '0;
      rsp_valid <= 1'b0;
      rsp_i1    <= '0;
      rsp_i2    <= '0;
      rsp_d     <= '0;
    end else begin
      state     <= state_nx;
      m_i1re    <= state_nx == P0;
      m_i2re    <= state_nx == P1;
      m_dre     <= state_nx == P2;
      m_gwe     <= state_nx == P3;
      m_dwe     <= we_q
                && (state_nx == P2 || state_nx == P3);
      rsp_valid <= state == P3;
      if (accept) begin
        m_i1addr <= req_i1a;
        m_i2addr <= req_i2a;
        m_daddr  <= req_da;
        m_din    <= req_din;
        we_q     <= req_we && we_ok;
      end
      // BRAM read data lands one phase after
      // its strobe, hence the one-phase lag.
      if (state == P1) begin
        rsp_i1 <= m_i1out;
      end
      if (state == P2) begin
        rsp_i2 <= m_i2out;
      end
      if (state == P3) begin
        rsp_d <= m_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_phase_seq.sv
// tb_mem_phase_seq: bench for mem_phase_seq with a BRAM model
// and a cycle-scheduled reference of strobes and responses.
module tb_mem_phase_seq;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_i1a = '0;
  logic [AW-1:0] req_i2a = '0;
  logic [AW-1:0] req_da  = '0;
  logic [DW-1:0] req_din = '0;
  logic          req_we  = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_i1, rsp_i2, rsp_d;
  logic          m_i1re, m_i2re, m_dre, m_gwe;
  logic [AW-1:0] m_i1addr, m_i2addr, m_daddr;
  logic [DW-1:0] m_din;
  logic          m_dwe;
  logic [DW-1:0] m_i1out, m_i2out, m_dout;
  logic          err;

  always #5 clk = ~clk;

  mem_phase_seq #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_i1a(req_i1a),
    .req_i2a(req_i2a),
    .req_da(req_da),
    .req_din(req_din),
    .req_we(req_we),
    .rsp_valid(rsp_valid),
    .rsp_i1(rsp_i1),
    .rsp_i2(rsp_i2),
    .rsp_d(rsp_d),
    .m_i1re(m_i1re),
    .m_i2re(m_i2re),
    .m_dre(m_dre),
    .m_gwe(m_gwe),
    .m_i1addr(m_i1addr),
    .m_i2addr(m_i2addr),
    .m_daddr(m_daddr),
    .m_din(m_din),
    .m_dwe(m_dwe),
    .m_i1out(m_i1out),
    .m_i2out(m_i2out),
    .m_dout(m_dout),
    .err(err)
  );

  // BRAM: synchronous read-first, write when dre and dwe.
  logic [DW-1:0] mi [DEPTH];
  logic [DW-1:0] md [DEPTH];
  int dwe_cnt = 0;

  always @(posedge clk) begin
    if (m_i1re) m_i1out <= mi[m_i1addr[9:0]];
    if (m_i2re) m_i2out <= mi[m_i2addr[9:0]];
    if (m_dre) begin
      m_dout <= md[m_daddr[9:0]];
      if (m_dwe) md[m_daddr[9:0]] <= m_din;
    end
    if (m_dwe) dwe_cnt++;
  end

  // Reference: each accept at cycle t schedules events
  // for cycles t+1..t+5; reset drops everything pending.
  typedef struct packed {
    logic [3:0]    st;
    logic          dwe;
    logic          rv;
    logic [DW-1:0] i1;
    logic [DW-1:0] i2;
    logic [DW-1:0] d;
    logic          wr;
    logic [9:0]    wa;
    logic [DW-1:0] wd;
  } ev_t;

  ev_t sched [int];
  logic [DW-1:0] si [DEPTH];
  logic [DW-1:0] sd [DEPTH];
  int cyc = 0;
  int last_acc = -100;
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] e_i1a = '0, e_i2a = '0, e_da = '0;
  logic [DW-1:0] e_din = '0;
  logic e_err = 1'b0;
  int rv_t[$];

  function automatic ev_t get_ev(int k);
    if (sched.exists(k)) return sched[k];
    return '0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    int c;
    ev_t e;
    logic inr;
    c = cyc;
    if (sched.exists(c)) begin
      e = sched[c];
      if (e.wr) sd[e.wa] = e.wd;
      sched.delete(c);
    end
    if (rst) begin
      sched.delete();
      last_acc = -100;
      e_i1a = '0;
      e_i2a = '0;
      e_da  = '0;
      e_din = '0;
      e_err = 1'b0;
    end else if (req_valid && (c - last_acc >= 4)) begin
      last_acc = c;
      e_i1a = req_i1a;
      e_i2a = req_i2a;
      e_da  = req_da;
      e_din = req_din;
      inr = 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
      if (req_i1a >= DEPTH || req_i2a >= DEPTH || req_da >= DEPTH)
        e_err = 1'b1;
      inr = req_da < DEPTH;
`endif
      for (int i = 1; i <= 4; i++) begin
        e = get_ev(c + i);
        e.st = 4'(1 << (i - 1));
        if (i >= 3) e.dwe = req_we && inr;
        if (i == 3) begin
          e.wr = req_we && inr;
          e.wa = req_da[9:0];
          e.wd = req_din;
        end
        sched[c + i] = e;
      end
      e = get_ev(c + 5);
      e.rv = 1'b1;
      e.i1 = si[req_i1a[9:0]];
      e.i2 = si[req_i2a[9:0]];
      e.d  = sd[req_da[9:0]];
      sched[c + 5] = e;
    end
    cyc = c + 1;
    #1;
    e = get_ev(c + 1);
    chk("strobes", 32'({m_gwe, m_dre, m_i2re, m_i1re}), 32'(e.st));
    chk("m_dwe", 32'(m_dwe), 32'(e.dwe));
    chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
    if (e.rv) begin
      rv_t.push_back(c + 1);
      chk("rsp_i1", 32'(rsp_i1), 32'(e.i1));
      chk("rsp_i2", 32'(rsp_i2), 32'(e.i2));
      chk("rsp_d", 32'(rsp_d), 32'(e.d));
    end
    chk("req_ready", 32'(req_ready),
        32'(!rst && ((c + 1) - last_acc >= 4)));
    chk("m_i1addr", 32'(m_i1addr), 32'(e_i1a));
    chk("m_i2addr", 32'(m_i2addr), 32'(e_i2a));
    chk("m_daddr", 32'(m_daddr), 32'(e_da));
    chk("m_din", 32'(m_din), 32'(e_din));
    chk("err", 32'(err), 32'(e_err));
  end

  task automatic send(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [AW-1:0] da, input logic [DW-1:0] din,
                      input logic we, input logic hold, output time tacc);
    int n;
    n = 0;
    @(negedge clk);
    req_i1a = a1;
    req_i2a = a2;
    req_da  = da;
    req_din = din;
    req_we  = we;
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout t=%0t got=busy exp=ready", $time);
    end
    @(posedge clk);
    tacc = $time;
    if (!hold) begin
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!rsp_valid && n < 12);
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s_timeout t=%0t got=no_rsp exp=rsp", nm, $time);
    end
  endtask

  initial begin : stim
    time t0;
    int nrv, ndw;
    for (int i = 0; i < DEPTH; i++) begin
      mi[i] = DW'($urandom);
      md[i] = DW'($urandom);
    end
    mi[5] = 16'h1234;
    mi[6] = 16'hABCD;
    md[9] = 16'h0042;
    md[3] = 16'h5A5A;
    si = mi;
    sd = md;

    // reset then idle
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_strb", 32'({m_gwe, m_dre, m_i2re, m_i1re}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // single read with strobe rotation and latency
    send(16'd5, 16'd6, 16'd9, 16'd0, 1'b0, 1'b0, t0);
    #1;
    chk("s2_strb0", 32'({m_gwe, m_dre, m_i2re, m_i1re}), 32'h1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("s2_strb", 32'({m_gwe, m_dre, m_i2re, m_i1re}), 32'(1 << i));
    end
    @(posedge clk);
    #2;
    chk("s2_valid", 32'(rsp_valid), 32'd1);
    chk("s2_lat", 32'($time - 2 - t0), 32'd40);
    chk("s2_i1", 32'(rsp_i1), 32'h1234);
    chk("s2_i2", 32'(rsp_i2), 32'hABCD);
    chk("s2_d", 32'(rsp_d), 32'h0042);

    // store returns old value, load sees new one
    send(16'd0, 16'd1, 16'd9, 16'hBEEF, 1'b1, 1'b0, t0);
    wait_rsp("s3a");
    chk("s3_pre", 32'(rsp_d), 32'h0042);
    send(16'd2, 16'd3, 16'd9, 16'd0, 1'b0, 1'b0, t0);
    wait_rsp("s3b");
    chk("s3_post", 32'(rsp_d), 32'hBEEF);

    // back-to-back
    repeat (2) @(negedge clk);
    rv_t.delete();
    send(16'd10, 16'd11, 16'd12, 16'h1111, 1'b1, 1'b1, t0);
    send(16'd12, 16'd13, 16'd14, 16'h2222, 1'b0, 1'b1, t0);
    send(16'd14, 16'd15, 16'd12, 16'h3333, 1'b1, 1'b0, t0);
    repeat (10) @(posedge clk);
    #2;
    chk("b2b_cnt", 32'(rv_t.size()), 32'd3);
    if (rv_t.size() == 3) begin
      chk("b2b_gap1", 32'(rv_t[1] - rv_t[0]), 32'd4);
      chk("b2b_gap2", 32'(rv_t[2] - rv_t[1]), 32'd4);
    end

    // reset in P1 of a store
    nrv = rv_t.size();
    ndw = dwe_cnt;
    send(16'd7, 16'd8, 16'd3, 16'hDEAD, 1'b1, 1'b0, t0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("s5_dwe", 32'(dwe_cnt - ndw), 32'd0);
    chk("s5_mem", 32'(md[3]), 32'h5A5A);
    chk("s5_norsp", 32'(rv_t.size() - nrv), 32'd0);
    chk("s5_idle", 32'(req_ready), 32'd1);

`ifdef MEM_BOUNDS_CHECK_EN
    ndw = dwe_cnt;
    send(16'd1, 16'd2, 16'd1024, 16'h7777, 1'b1, 1'b0, t0);
    wait_rsp("s6a");
    chk("s6_err", 32'(err), 32'd1);
    chk("s6_dwe", 32'(dwe_cnt - ndw), 32'd0);
    send(16'd5, 16'd6, 16'd4, 16'd0, 1'b0, 1'b0, t0);
    wait_rsp("s6b");
    chk("s6_err_hold", 32'(err), 32'd1);
    chk("s6_i1", 32'(rsp_i1), 32'h1234);
`endif

    // randomized traffic on a small address window
    for (int k = 0; k < 40; k++) begin
      send(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
           AW'($urandom_range(0, 15)), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=done", $time);
    $fatal(1);
  end

endmodule
